fu_matrix_ls_seq: RTL and testbench

Parametrised, queued successor to the single-shot matrix load/store functional unit. It accepts matrix load/store instructions from the issue queue into a small instruction FIFO. It expands each instruction into ROWS strided per-row scratchpad requests, sequenced on `mhit`, and signals completion with the destination matrix register. It sits between the issue queue and the scratchpad port, and the matrix register file consumes its per-row and completion signals.

---
 rtl/datapath_pkg.sv | 22 ++
 rtl/matls_instr_fifo.sv | 53 +++++
 rtl/fu_matrix_ls_seq.sv | 136 +++++++++++++
 tb/tb_fu_matrix_ls_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the queued matrix load/store unit.
// regbits_t is the architectural matrix register index.
package isa_pkg;
    typedef logic [3:0] regbits_t;
endpackage

package datapath_pkg;
    import isa_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } matls_state_t;

    typedef struct packed {
        logic        ls;
        regbits_t    rd;
        logic [31:0] base;
        logic [31:0] stride;
    } matls_entry_t;
endpackage

// File: rtl/matls_instr_fifo.sv
// Instruction FIFO for the matrix load/store unit.
// Power-of-two depth, so the pointers wrap by overflow.
module matls_instr_fifo
    import datapath_pkg::*;
#(
    parameter int  QDEPTH  = 2,
    parameter type entry_t = matls_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   empty,
    output logic   full
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    entry_t          mem_q [QDEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(QDEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/fu_matrix_ls_seq.sv
// Queued matrix load/store unit: expands each instruction into
// ROWS strided scratchpad row requests sequenced on mhit.
module fu_matrix_ls_seq
    import datapath_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int RD_W   = 4,
    parameter int ROWS   = 4,
    parameter int QDEPTH = 2,
    localparam int RW    = $clog2(ROWS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    output logic              ready,
    input  logic              ls_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [WORD_W-1:0] rs_in,
    input  logic [WORD_W-1:0] imm_in,
    input  logic [WORD_W-1:0] stride_in,
    input  logic              mhit,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [WORD_W-1:0] mem_addr,
    output logic [RW-1:0]     mem_row,
    output logic [RD_W-1:0]   mem_rd,
    output logic              done,
    output logic [RD_W-1:0]   done_rd,
    output logic              done_ls,
    output logic              busy
);
    typedef struct packed {
        logic              ls;
        logic [RD_W-1:0]   rd;
        logic [WORD_W-1:0] base;
        logic [WORD_W-1:0] stride;
    } entry_t;

    matls_state_t      state_q, state_d;
    logic              ls_q, ls_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] stride_q, stride_d;
    logic [RW-1:0]     row_q, row_d;

    entry_t wentry;
    entry_t head;
    logic   push;
    logic   pop;
    logic   empty;
    logic   full;

    assign push   = enable && ready;
    assign wentry = '{ls: ls_in, rd: rd_in,
                      base: rs_in + imm_in, stride: stride_in};

    matls_instr_fifo #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .full  (full)
    );

    // DONE may pop directly so back-to-back ops skip IDLE.
    always_comb begin
        state_d  = state_q;
        ls_d     = ls_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        row_d    = row_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: pop = !empty;
            REQ: begin
                if (mhit) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d  = row_q + 1'b1;
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                pop     = !empty;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d  = REQ;
            ls_d     = head.ls;
            rd_d     = head.rd;
            addr_d   = head.base;
            stride_d = head.stride;
            row_d    = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ls_q     <= 1'b0;
            rd_q     <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            ls_q     <= ls_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            row_q    <= row_d;
        end
    end

    assign ready    = !full;
    assign busy     = !empty || (state_q != IDLE);
    assign mem_ren  = (state_q == REQ) && !ls_q;
    assign mem_wen  = (state_q == REQ) && ls_q;
    assign mem_addr = addr_q;
    assign mem_row  = row_q;
    assign mem_rd   = rd_q;
    assign done     = (state_q == DONE);
    assign done_rd  = rd_q;
    assign done_ls  = ls_q;
endmodule

// File: tb/tb_fu_matrix_ls_seq.sv
// Self-checking bench: vector table plus scoreboard of expected
// row requests and completions, with hand-written corner sequences.
module tb_fu_matrix_ls_seq;
    localparam int WORD_W = 32;
    localparam int RD_W   = 4;
    localparam int ROWS   = 4;
    localparam int QDEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        ready;
    logic        ls_in;
    logic [3:0]  rd_in;
    logic [31:0] rs_in;
    logic [31:0] imm_in;
    logic [31:0] stride_in;
    logic        mhit;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [1:0]  mem_row;
    logic [3:0]  mem_rd;
    logic        done;
    logic [3:0]  done_rd;
    logic        done_ls;
    logic        busy;

    typedef struct {
        bit          is_done;
        bit          ls;
        logic [3:0]  rd;
        logic [31:0] addr;
        logic [1:0]  row;
    } exp_t;

    typedef struct {
        bit          ls;
        logic [3:0]  rd;
        logic [31:0] rs;
        logic [31:0] imm;
        logic [31:0] stride;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic [31:0] last_addr = '0;

    always #5 CLK = ~CLK;

    fu_matrix_ls_seq #(
        .WORD_W (WORD_W),
        .RD_W   (RD_W),
        .ROWS   (ROWS),
        .QDEPTH (QDEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .ready     (ready),
        .ls_in     (ls_in),
        .rd_in     (rd_in),
        .rs_in     (rs_in),
        .imm_in    (imm_in),
        .stride_in (stride_in),
        .mhit      (mhit),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_row   (mem_row),
        .mem_rd    (mem_rd),
        .done      (done),
        .done_rd   (done_rd),
        .done_ls   (done_ls),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic sb_underflow(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT output with empty scoreboard", nm);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input bit ls, input logic [3:0] rd,
                         input logic [31:0] rs, input logic [31:0] imm,
                         input logic [31:0] stride);
        logic [31:0] base;
        enable    = 1'b1;
        ls_in     = ls;
        rd_in     = rd;
        rs_in     = rs;
        imm_in    = imm;
        stride_in = stride;
        if (ready) begin
            base = rs + imm;
            for (int r = 0; r < ROWS; r++)
                sb.push_back('{1'b0, ls, rd,
                               base + 32'(r) * stride, 2'(r)});
            sb.push_back('{1'b1, ls, rd, 32'h0, 2'h0});
        end
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle", 32'(busy), 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(ready),   32'h1);
        chk({tag, "_busy"},    32'(busy),    32'h0);
        chk({tag, "_ren"},     32'(mem_ren), 32'h0);
        chk({tag, "_wen"},     32'(mem_wen), 32'h0);
        chk({tag, "_done"},    32'(done),    32'h0);
        chk({tag, "_addr"},    mem_addr,     32'h0);
        chk({tag, "_row"},     32'(mem_row), 32'h0);
        chk({tag, "_mem_rd"},  32'(mem_rd),  32'h0);
        chk({tag, "_done_rd"}, 32'(done_rd), 32'h0);
        chk({tag, "_done_ls"}, 32'(done_ls), 32'h0);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (mem_ren && mem_wen)
                chk("ren_wen_excl", 32'(mem_ren & mem_wen), 32'h0);
            if ((mem_ren || mem_wen) && mhit) begin
                if (sb.size() == 0) begin
                    sb_underflow("req");
                end else begin
                    e = sb.pop_front();
                    chk("req_kind", 32'(e.is_done), 32'h0);
                    chk("req_wen",  32'(mem_wen), 32'(e.ls));
                    chk("req_rd",   32'(mem_rd), 32'(e.rd));
                    chk("req_addr", mem_addr, e.addr);
                    chk("req_row",  32'(mem_row), 32'(e.row));
                    last_addr = mem_addr;
                end
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    sb_underflow("done");
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'h1);
                    chk("done_rd",   32'(done_rd), 32'(e.rd));
                    chk("done_ls",   32'(done_ls), 32'(e.ls));
                end
            end
        end
    end

    vec_t vt[4];
    int   n;
    int   snap;

    initial begin
        vt[0] = '{1'b0, 4'h3, 32'h100, 32'h20, 32'h40,
                  32'h120, 32'h1E0};
        vt[1] = '{1'b0, 4'hA, 32'hFFFFFFE0, 32'h10, 32'h10,
                  32'hFFFFFFF0, 32'h20};
        vt[2] = '{1'b1, 4'hF, 32'h1000, 32'h0, 32'h0,
                  32'h1000, 32'h1000};
        vt[3] = '{1'b1, 4'h0, 32'h80, 32'hFFFFFFF8, 32'hFFFFFFFC,
                  32'h78, 32'h6C};

        RST = 1'b1;
        enable = 1'b0;
        ls_in = 1'b0;
        rd_in = '0;
        rs_in = '0;
        imm_in = '0;
        stride_in = '0;
        mhit = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Table-driven single instructions, mhit always high.
        mhit = 1'b1;
        for (int v = 0; v < 4; v++) begin
            issue(vt[v].ls, vt[v].rd, vt[v].rs, vt[v].imm, vt[v].stride);
            chk("pre_req", 32'({mem_ren, mem_wen}), 32'h0);
            chk("pre_busy", 32'(busy), 32'h1);
            tick();
            chk("first_ren", 32'(mem_ren), 32'(!vt[v].ls));
            chk("first_wen", 32'(mem_wen), 32'(vt[v].ls));
            chk("first_row", 32'(mem_row), 32'h0);
            chk("first_addr", mem_addr, vt[v].first_addr);
            n = 0;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            chk("req_cycles", 32'(n), 32'(ROWS));
            tick();
            chk("done_pulse", 32'(done), 32'h0);
            chk("last_addr", last_addr, vt[v].last_addr);
            wait_idle(10);
        end

        // Store with a 3-cycle mhit stall on row 1.
        issue(1'b1, 4'h5, 32'h200, 32'h0, 32'h4);
        tick();
        n = 0;
        tick();
        n++;
        mhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n++;
            chk("stall_row", 32'(mem_row), 32'h1);
            chk("stall_addr", mem_addr, 32'h204);
            chk("stall_wen", 32'(mem_wen), 32'h1);
            chk("stall_done", 32'(done), 32'h0);
        end
        mhit = 1'b1;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("stall_latency", 32'(n), 32'(ROWS + 3));
        wait_idle(10);

        // FIFO full: active op plus two queued, fourth enable dropped.
        mhit = 1'b0;
        snap = done_cnt;
        issue(1'b0, 4'h1, 32'h0, 32'h0, 32'h8);
        tick();
        issue(1'b0, 4'h2, 32'h40, 32'h0, 32'h8);
        chk("ready_one", 32'(ready), 32'h1);
        issue(1'b1, 4'h3, 32'h80, 32'h0, 32'h8);
        chk("ready_full", 32'(ready), 32'h0);
        issue(1'b0, 4'h4, 32'hC0, 32'h0, 32'h8);
        chk("ready_still_full", 32'(ready), 32'h0);
        mhit = 1'b1;
        wait_idle(60);
        chk("full_done_count", 32'(done_cnt - snap), 32'h3);

        // Reset in the middle of row 2.
        issue(1'b0, 4'h6, 32'h300, 32'h0, 32'h10);
        n = 0;
        while (mem_row != 2'd2 && n < 10) begin
            tick();
            n++;
        end
        chk("reached_row2", 32'(mem_row), 32'h2);
        RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        snap = done_cnt;
        repeat (2) tick();
        RST = 1'b0;
        repeat (3) tick();
        chk("midrst_no_done", 32'(done_cnt - snap), 32'h0);
        chk("midrst_idle", 32'(busy), 32'h0);
        issue(1'b0, 4'h7, 32'h400, 32'h0, 32'h8);
        tick();
        chk("post_rst_row", 32'(mem_row), 32'h0);
        chk("post_rst_ren", 32'(mem_ren), 32'h1);
        chk("post_rst_addr", mem_addr, 32'h400);
        wait_idle(10);

        // Push and pop in the same DONE cycle.
        issue(1'b0, 4'h8, 32'h500, 32'h0, 32'h4);
        issue(1'b1, 4'h9, 32'h600, 32'h0, 32'h4);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("pp_in_done", 32'(done), 32'h1);
        chk("pp_ready_pre", 32'(ready), 32'h1);
        issue(1'b0, 4'hA, 32'h700, 32'h0, 32'h4);
        chk("pp_next_wen", 32'(mem_wen), 32'h1);
        chk("pp_next_row", 32'(mem_row), 32'h0);
        chk("pp_next_rd", 32'(mem_rd), 32'h9);
        chk("pp_ready", 32'(ready), 32'h1);
        chk("pp_done_low", 32'(done), 32'h0);
        wait_idle(40);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
